mem_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the 256-word LC-3 main memory. The memory has a combinational read and a synchronous write. This block sits between the memory and two masters: port 0 is the CPU MAR/MDR path, and port 1 is the loader/IO path. It grants one master at a time, registers the address and write data, drives the memory's write enable for exactly one cycle, captures read data, and returns a single-cycle acknowledge to the requester.

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter and access sequencer for the 256-word LC-3 main memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority to port 0.
module mem_arbiter #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic        err,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_owner;
  logic        r_we;
  logic        r_err;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        w_any;
  logic        w_gnt1;
  logic        w_in_range;

  assign w_any = req0 | req1;
  // Full 16-bit compare: addresses past DEPTH never alias low words
  assign w_in_range = ({16'h0000, r_addr} < 32'(DEPTH));

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last;

  assign w_gnt1 = req1 & (~req0 | ~r_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (r_state == S_IDLE && w_any) begin
      r_last <= w_gnt1;
    end
  end
`else
  assign w_gnt1 = req1 & ~req0;
`endif

  always_comb begin
    w_next = r_state;
    mem_we = 1'b0;
    ack0   = 1'b0;
    ack1   = 1'b0;
    err    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        w_next = S_RESP;
        mem_we = r_we & w_in_range;
      end
      S_RESP: begin
        w_next = S_IDLE;
        ack0   = ~r_owner;
        ack1   = r_owner;
        err    = r_err;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
      r_rdata <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_any) begin
        r_owner <= w_gnt1;
        r_we    <= w_gnt1 ? we1 : we0;
        r_addr  <= w_gnt1 ? addr1 : addr0;
        r_wdata <= w_gnt1 ? wdata1 : wdata0;
      end
      if (r_state == S_ACCESS) begin
        r_err <= ~w_in_range;
        if (!r_we) r_rdata <= w_in_range ? mem_rdata : 16'h0000;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus random two-port traffic
// checked against an array-based memory/range model.
module tb_mem_arbiter;

  localparam int DEPTH = 256;

  typedef struct {
    logic        wr;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err, busy, mem_we;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  exp_t        q0 [$];
  exp_t        q1 [$];
  wr_t         wq_even [$];
  wr_t         wq_odd [$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  mem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] initv(input int i);
    return 16'(i * 37 + 32'h1000);
  endfunction

  initial for (int i = 0; i < 256; i++) mem[i] = initv(i);
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT acks or writes memory
  logic [15:0] last_rd = 16'h0000;
  logic        prev_we = 1'b0;

  task automatic take_ack(input int p);
    exp_t e;
    n_chk++;
    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
      n_fail++;
      $display("FAIL unexpected_ack%0d: got ack expected none", p);
      return;
    end
    e = (p == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("err%0d", p), err, e.err);
    if (e.wr) begin
      chk($sformatf("wr_keeps_rdata%0d", p), rdata, last_rd);
    end else begin
      chk($sformatf("rdata%0d", p), rdata, e.rdata);
      last_rd = e.rdata;
    end
  endtask

  initial forever begin
    wr_t w;
    @(negedge clk);
    if (reset) begin
      last_rd = 16'h0000;
      prev_we = 1'b0;
      continue;
    end
    chk("one_hot_ack", ack0 & ack1, 1'b0);
    if (mem_we) begin
      chk("we_single_cycle", prev_we, 1'b0);
      n_chk++;
      if ((mem_addr[0] && wq_odd.size() == 0) ||
          (!mem_addr[0] && wq_even.size() == 0)) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %h expected no write", mem_addr);
      end else begin
        w = mem_addr[0] ? wq_odd.pop_front() : wq_even.pop_front();
        chk("mem_addr", mem_addr, w.addr);
        chk("mem_wdata", mem_wdata, w.data);
      end
    end
    prev_we = mem_we;
    if (ack0) take_ack(0);
    if (ack1) take_ack(1);
    if (!ack0 && !ack1) chk("err_without_ack", err, 1'b0);
  end

  // One transaction: model the result, queue it, drive until ack, then release
  task automatic issue(input int p, input logic w, input logic [15:0] a,
                       input logic [15:0] d, output int lat);
    exp_t e;
    int   st;
    e.wr    = w;
    e.err   = (32'(a) >= DEPTH);
    e.rdata = e.err ? 16'h0000 : ref_mem[a[7:0]];
    if (w && !e.err) begin
      ref_mem[a[7:0]] = d;
      if (a[0]) wq_odd.push_back('{addr: a, data: d});
      else wq_even.push_back('{addr: a, data: d});
    end
    if (p == 0) begin
      q0.push_back(e);
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      q1.push_back(e);
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    end
    st  = cyc;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((p == 0 && ack0) || (p == 1 && ack1)) begin
        lat = cyc - st;
        break;
      end
    end
    chk($sformatf("ack_seen%0d", p), 32'(lat >= 0), 1);
    @(posedge clk);
    #1;
    if (p == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  task automatic rnd_port(input int p, input int n);
    int          lat;
    logic [15:0] a;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 9) == 0) a = 16'(32'h100 + $urandom_range(0, 32'hFEFF));
      else a = 16'(($urandom_range(0, 127) << 1) | p);
      issue(p, 1'($urandom_range(0, 1)), a, 16'($urandom), lat);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk($sformatf("rr_lat%0d", p), 32'(lat >= 2 && lat <= 5), 1);
`else
      if (p == 0) chk("fp_lat0", 32'(lat >= 2 && lat <= 5), 1);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int l0 [4];
    int l1;
    for (int i = 0; i < 256; i++) ref_mem[i] = initv(i);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ack0", ack0, 1'b0);
    chk("rst_ack1", ack1, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", mem_wdata, 16'h0000);
    chk("rst_rdata", rdata, 16'h0000);
    @(posedge clk);
    #1;

    issue(0, 1'b1, 16'h0010, 16'hBEEF, lat);
    chk("wr0_lat", lat, 2);
    issue(1, 1'b0, 16'h0010, 16'h0000, lat);
    chk("rd1_lat", lat, 2);

    issue(1, 1'b1, 16'h0100, 16'h5555, lat);
    issue(1, 1'b0, 16'h0100, 16'h0000, lat);
    issue(1, 1'b0, 16'hFFFF, 16'h0000, lat);
    issue(0, 1'b0, 16'h0000, 16'h0000, lat);

    // Reset pulsed while a write to 0x20 sits in ACCESS
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0020; wdata0 = 16'h1234;
    @(posedge clk);
    #1;
    chk("mid_we_before", mem_we, 1'b1);
    chk("mid_addr_before", mem_addr, 16'h0020);
    #1 reset = 1'b1;
    #1;
    req0 = 1'b0;
    chk("mid_we_after", mem_we, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_addr", mem_addr, 16'h0000);
    chk("mid_wdata", mem_wdata, 16'h0000);
    chk("mid_rdata", rdata, 16'h0000);
    chk("mid_acks", {ack0, ack1, err}, 3'b000);
    @(posedge clk);
    #1 reset = 1'b0;

    // Tie in the first cycle after reset
    fork
      begin
        for (int k = 0; k < 4; k++) issue(0, 1'b0, 16'(32'h40 + 2 * k), 16'h0, l0[k]);
      end
      issue(1, 1'b0, 16'h0041, 16'h0, l1);
    join
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("tie_rr_l0_0", l0[0], 2);
    chk("tie_rr_l1", l1, 5);
    chk("tie_rr_l0_1", l0[1], 5);
    chk("tie_rr_l0_2", l0[2], 2);
`else
    chk("tie_fp_l0_0", l0[0], 2);
    chk("tie_fp_l0_1", l0[1], 2);
    chk("tie_fp_l0_3", l0[3], 2);
    chk("tie_fp_l1", l1, 14);
`endif
    issue(1, 1'b0, 16'h0020, 16'h0000, lat);

    // Back-to-back writes with busy watched every cycle
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          issue(0, 1'b1, 16'(32'h50 + 2 * k), 16'(32'hC000 + k), l0[k]);
          chk($sformatf("b2b_lat%0d", k), l0[k], 2);
        end
      end
      begin
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          chk($sformatf("b2b_busy%0d", k), busy, 1'((k % 3) != 0));
        end
      end
    join
    for (int k = 0; k < 4; k++) issue(1, 1'b0, 16'(32'h50 + 2 * k), 16'h0, lat);

    fork
      rnd_port(0, 30);
      rnd_port(1, 30);
    join
    repeat (3) @(posedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("wq_drained", wq_even.size() + wq_odd.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
